video_request_arbiter: RTL and testbench

// - Shares one upstream video source (generator or framebuffer) between two downstream pipelines.
// - Each pipeline issues chunk requests {row, chunk}. One request is outstanding at a time.
// - Requests are granted round-robin and forwarded upstream.
// - The 2**CHUNK_BITS response pixels are routed back to the pipeline that owns the request.
// - Sits between two VideoAggregateScaler upstream ports and one VideoGeneratorSource.

---
 rtl/video_request_arbiter.sv | 127 ++++++++++++
 tb/tb_video_request_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_request_arbiter.sv
// Round-robin arbiter sharing one upstream video source between two downstream
// pipelines: one chunk request in flight, response pixels routed back to its owner.
module video_request_arbiter #(
  parameter int CHUNK_BITS     = 5,
  parameter int HACTIVE_BITS   = 11,
  parameter int VACTIVE_BITS   = 11,
  parameter int BITS_PER_PIXEL = 16,
  localparam int REQUEST_BITS  = VACTIVE_BITS + HACTIVE_BITS - CHUNK_BITS
) (
  input  logic                      scalerClock,
  input  logic                      reset,

  output logic                      ds0RequestFifoReadEnable,
  input  logic                      ds0RequestFifoEmpty,
  input  logic [REQUEST_BITS-1:0]   ds0RequestFifoReadData,
  output logic                      ds0ResponseFifoWriteEnable,
  input  logic                      ds0ResponseFifoFull,
  output logic [BITS_PER_PIXEL-1:0] ds0ResponseFifoWriteData,

  output logic                      ds1RequestFifoReadEnable,
  input  logic                      ds1RequestFifoEmpty,
  input  logic [REQUEST_BITS-1:0]   ds1RequestFifoReadData,
  output logic                      ds1ResponseFifoWriteEnable,
  input  logic                      ds1ResponseFifoFull,
  output logic [BITS_PER_PIXEL-1:0] ds1ResponseFifoWriteData,

  input  logic                      upstreamRequestFifoReadEnable,
  output logic                      upstreamRequestFifoEmpty,
  output logic [REQUEST_BITS-1:0]   upstreamRequestFifoReadData,
  input  logic                      upstreamResponseFifoWriteEnable,
  output logic                      upstreamResponseFifoFull,
  input  logic [BITS_PER_PIXEL-1:0] upstreamResponseFifoWriteData,

  output logic                      owner,
  output logic                      protocolError
);

  typedef enum logic [1:0] {IDLE, OFFER, STREAM} state_t;

  state_t                  state_q, state_d;
  logic [REQUEST_BITS-1:0] req_q, req_d;
  logic                    owner_q, owner_d;
  logic                    last_served_q, last_served_d;
  logic [CHUNK_BITS-1:0]   count_q, count_d;
  logic                    protocol_error_q, protocol_error_d;

  logic req0, req1, grant_port, owner_full, in_stream;
  logic write_ok, final_write, arb_slot;

  always_comb begin
    req0        = !ds0RequestFifoEmpty;
    req1        = !ds1RequestFifoEmpty;
    grant_port  = (req0 && req1) ? !last_served_q : req1;
    owner_full  = owner_q ? ds1ResponseFifoFull : ds0ResponseFifoFull;
    in_stream   = (state_q == STREAM);
    write_ok    = in_stream && upstreamResponseFifoWriteEnable && !owner_full;
    final_write = write_ok && (count_q == '1);
    // Grants are held off while reset is asserted so no requester FIFO is popped.
    arb_slot    = reset && (req0 || req1) && ((state_q == IDLE) || final_write);

    state_d          = state_q;
    req_d            = req_q;
    owner_d          = owner_q;
    last_served_d    = last_served_q;
    count_d          = count_q;
    protocol_error_d = protocol_error_q;

    case (state_q)
      OFFER: begin
        if (upstreamRequestFifoReadEnable) begin
          state_d = STREAM;
          count_d = '0;
        end
      end
      STREAM: begin
        if (write_ok) begin
          count_d = count_q + CHUNK_BITS'(1);
          if (final_write) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The final write of a chunk may re-arbitrate directly into OFFER.
    if (arb_slot) begin
      state_d       = OFFER;
      req_d         = grant_port ? ds1RequestFifoReadData : ds0RequestFifoReadData;
      owner_d       = grant_port;
      last_served_d = grant_port;
    end

    if ((upstreamResponseFifoWriteEnable && (!in_stream || owner_full)) ||
        (upstreamRequestFifoReadEnable && (state_q != OFFER)))
      protocol_error_d = 1'b1;
  end

  always_ff @(posedge scalerClock or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      req_q            <= '0;
      owner_q          <= 1'b0;
      last_served_q    <= 1'b1;
      count_q          <= '0;
      protocol_error_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      req_q            <= req_d;
      owner_q          <= owner_d;
      last_served_q    <= last_served_d;
      count_q          <= count_d;
      protocol_error_q <= protocol_error_d;
    end
  end

  assign ds0RequestFifoReadEnable    = arb_slot && !grant_port;
  assign ds1RequestFifoReadEnable    = arb_slot && grant_port;
  assign ds0ResponseFifoWriteEnable  = write_ok && !owner_q;
  assign ds1ResponseFifoWriteEnable  = write_ok && owner_q;
  assign ds0ResponseFifoWriteData    = upstreamResponseFifoWriteData;
  assign ds1ResponseFifoWriteData    = upstreamResponseFifoWriteData;
  assign upstreamRequestFifoEmpty    = (state_q != OFFER);
  assign upstreamRequestFifoReadData = req_q;
  assign upstreamResponseFifoFull    = in_stream && owner_full;
  assign owner                       = owner_q;
  assign protocolError               = protocol_error_q;

endmodule

// File: tb/tb_video_request_arbiter.sv
// Scoreboard bench for video_request_arbiter: directed chunks, expected grants,
// offers and pixels queued by stimulus and popped by an independent monitor.
module tb_video_request_arbiter;

  localparam int RB = 17;
  localparam int PB = 16;

  logic scalerClock = 1'b0;
  logic reset = 1'b0;
  always #5 scalerClock = ~scalerClock;

  logic          ds0RequestFifoReadEnable, ds1RequestFifoReadEnable;
  logic          ds0RequestFifoEmpty = 1'b1, ds1RequestFifoEmpty = 1'b1;
  logic [RB-1:0] ds0RequestFifoReadData = '0, ds1RequestFifoReadData = '0;
  logic          ds0ResponseFifoWriteEnable, ds1ResponseFifoWriteEnable;
  logic          ds0ResponseFifoFull = 1'b0, ds1ResponseFifoFull = 1'b0;
  logic [PB-1:0] ds0ResponseFifoWriteData, ds1ResponseFifoWriteData;
  logic          upstreamRequestFifoReadEnable = 1'b0;
  logic          upstreamRequestFifoEmpty;
  logic [RB-1:0] upstreamRequestFifoReadData;
  logic          upstreamResponseFifoWriteEnable = 1'b0;
  logic          upstreamResponseFifoFull;
  logic [PB-1:0] upstreamResponseFifoWriteData = '0;
  logic          owner, protocolError;

  video_request_arbiter dut (
    .scalerClock                     (scalerClock),
    .reset                           (reset),
    .ds0RequestFifoReadEnable        (ds0RequestFifoReadEnable),
    .ds0RequestFifoEmpty             (ds0RequestFifoEmpty),
    .ds0RequestFifoReadData          (ds0RequestFifoReadData),
    .ds0ResponseFifoWriteEnable      (ds0ResponseFifoWriteEnable),
    .ds0ResponseFifoFull             (ds0ResponseFifoFull),
    .ds0ResponseFifoWriteData        (ds0ResponseFifoWriteData),
    .ds1RequestFifoReadEnable        (ds1RequestFifoReadEnable),
    .ds1RequestFifoEmpty             (ds1RequestFifoEmpty),
    .ds1RequestFifoReadData          (ds1RequestFifoReadData),
    .ds1ResponseFifoWriteEnable      (ds1ResponseFifoWriteEnable),
    .ds1ResponseFifoFull             (ds1ResponseFifoFull),
    .ds1ResponseFifoWriteData        (ds1ResponseFifoWriteData),
    .upstreamRequestFifoReadEnable   (upstreamRequestFifoReadEnable),
    .upstreamRequestFifoEmpty        (upstreamRequestFifoEmpty),
    .upstreamRequestFifoReadData     (upstreamRequestFifoReadData),
    .upstreamResponseFifoWriteEnable (upstreamResponseFifoWriteEnable),
    .upstreamResponseFifoFull        (upstreamResponseFifoFull),
    .upstreamResponseFifoWriteData   (upstreamResponseFifoWriteData),
    .owner                           (owner),
    .protocolError                   (protocolError)
  );

  typedef struct packed {
    logic          port;
    logic [PB-1:0] data;
  } resp_t;

  logic [RB-1:0] ds0_fifo[$];
  logic [RB-1:0] ds1_fifo[$];
  logic          grant_q[$];
  logic [RB-1:0] offer_q[$];
  resp_t         resp_q[$];

  int errors = 0;
  int checks = 0;
  int full_cycles = 0;
  logic pop0, pop1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Requester FIFO model: pop a cycle's granted head, then republish head/empty.
  always @(posedge scalerClock) begin
    pop0 = ds0RequestFifoReadEnable;
    pop1 = ds1RequestFifoReadEnable;
    #1;
    if (pop0 && ds0_fifo.size() > 0) void'(ds0_fifo.pop_front());
    if (pop1 && ds1_fifo.size() > 0) void'(ds1_fifo.pop_front());
    #1;
    ds0RequestFifoEmpty    = (ds0_fifo.size() == 0);
    ds1RequestFifoEmpty    = (ds1_fifo.size() == 0);
    ds0RequestFifoReadData = (ds0_fifo.size() == 0) ? '0 : ds0_fifo[0];
    ds1RequestFifoReadData = (ds1_fifo.size() == 0) ? '0 : ds1_fifo[0];
  end

  // Monitor: every grant, offer pop and pixel push is matched against the scoreboard.
  always @(negedge scalerClock) begin
    if (upstreamResponseFifoFull) full_cycles++;
    if (ds0RequestFifoReadEnable || ds1RequestFifoReadEnable) begin
      if (grant_q.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_grant actual=%0b%0b required=none",
                 ds1RequestFifoReadEnable, ds0RequestFifoReadEnable);
      end else begin
        logic gp;
        gp = grant_q.pop_front();
        check_output("grant_onehot", {30'd0, ds1RequestFifoReadEnable, ds0RequestFifoReadEnable},
                     gp ? 32'd2 : 32'd1);
      end
    end
    if (upstreamRequestFifoReadEnable && !upstreamRequestFifoEmpty) begin
      if (offer_q.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_offer actual=%0h required=none", upstreamRequestFifoReadData);
      end else begin
        check_output("offer_data", 32'(upstreamRequestFifoReadData), 32'(offer_q.pop_front()));
      end
    end
    if (ds0ResponseFifoWriteEnable || ds1ResponseFifoWriteEnable) begin
      if (resp_q.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_write actual=%0b%0b required=none",
                 ds1ResponseFifoWriteEnable, ds0ResponseFifoWriteEnable);
      end else begin
        resp_t e;
        e = resp_q.pop_front();
        check_output("resp_port", {30'd0, ds1ResponseFifoWriteEnable, ds0ResponseFifoWriteEnable},
                     e.port ? 32'd2 : 32'd1);
        check_output("resp_data",
                     32'(ds1ResponseFifoWriteEnable ? ds1ResponseFifoWriteData : ds0ResponseFifoWriteData),
                     32'(e.data));
        check_output("resp_into_full",
                     32'(ds1ResponseFifoWriteEnable ? ds1ResponseFifoFull : ds0ResponseFifoFull), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge scalerClock);
    #1;
  endtask

  // Acts as the upstream source for one chunk: pop the offer, then push nwords pixels.
  task automatic serve_chunk(input logic port, input logic [RB-1:0] req, input logic [PB-1:0] base,
                             input int nwords, input bit stall, input bit expect_b2b);
    int waited;
    waited = 0;
    offer_q.push_back(req);
    while (upstreamRequestFifoEmpty && waited < 50) begin
      tick();
      waited++;
    end
    if (upstreamRequestFifoEmpty) begin
      check_output("offer_timeout", 32'(upstreamRequestFifoEmpty), 32'd0);
      return;
    end
    upstreamRequestFifoReadEnable = 1'b1;
    tick();
    upstreamRequestFifoReadEnable = 1'b0;
    check_output("owner", 32'(owner), 32'(port));
    for (int i = 0; i < nwords; i++) begin
      if (stall && i == 10) begin
        upstreamResponseFifoWriteEnable = 1'b0;
        ds1ResponseFifoFull = 1'b1;
        repeat (5) tick();
        ds1ResponseFifoFull = 1'b0;
      end
      upstreamResponseFifoWriteEnable = 1'b1;
      upstreamResponseFifoWriteData   = base + PB'(i);
      resp_q.push_back(resp_t'{port: port, data: base + PB'(i)});
      tick();
    end
    upstreamResponseFifoWriteEnable = 1'b0;
    if (nwords == 32)
      check_output("next_offer_after_chunk", 32'(upstreamRequestFifoEmpty), expect_b2b ? 32'd0 : 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values
    repeat (2) tick();
    check_output("rst_up_empty", 32'(upstreamRequestFifoEmpty), 32'd1);
    check_output("rst_owner", 32'(owner), 32'd0);
    check_output("rst_perr", 32'(protocolError), 32'd0);
    check_output("rst_up_full", 32'(upstreamResponseFifoFull), 32'd0);
    check_output("rst_ds_we", {30'd0, ds1ResponseFifoWriteEnable, ds0ResponseFifoWriteEnable}, 32'd0);
    @(negedge scalerClock) reset = 1'b1;
    tick();

    // Single port-0 chunk
    ds0_fifo.push_back(17'h00105);
    grant_q.push_back(1'b0);
    #2;
    check_output("t1_ds0_re_pulse", 32'(ds0RequestFifoReadEnable), 32'd1);
    tick();
    check_output("t1_ds0_re_drop", 32'(ds0RequestFifoReadEnable), 32'd0);
    check_output("t1_offer_empty", 32'(upstreamRequestFifoEmpty), 32'd0);
    check_output("t1_offer_data", 32'(upstreamRequestFifoReadData), 32'h00105);
    serve_chunk(1'b0, 17'h00105, 16'h0000, 32, 1'b0, 1'b0);

    // Both ports loaded from reset: strict alternation, no bubbles
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ds0_fifo.push_back(17'h00200 + RB'(k));
      ds1_fifo.push_back(17'h10300 + RB'(k));
    end
    repeat (2) tick();
    check_output("t2_no_grant_in_reset", {30'd0, ds1RequestFifoReadEnable, ds0RequestFifoReadEnable}, 32'd0);
    for (int k = 0; k < 6; k++) grant_q.push_back(k[0]);
    @(negedge scalerClock) reset = 1'b1;
    for (int k = 0; k < 6; k++)
      serve_chunk(k[0], k[0] ? (17'h10300 + RB'(k / 2)) : (17'h00200 + RB'(k / 2)),
                  16'h1000 * PB'(k + 1), 32, 1'b0, k < 5);

    // ds1 back-pressure for 5 cycles mid-chunk
    ds1_fifo.push_back(17'h00777);
    grant_q.push_back(1'b1);
    full_cycles = 0;
    serve_chunk(1'b1, 17'h00777, 16'h3000, 32, 1'b1, 1'b0);
    check_output("t3_full_cycles", 32'(full_cycles), 32'd5);
    check_output("t3_perr_clear", 32'(protocolError), 32'd0);

    // Upstream write while idle
    upstreamResponseFifoWriteEnable = 1'b1;
    upstreamResponseFifoWriteData   = 16'hBEEF;
    #1;
    check_output("t4_no_ds_write", {30'd0, ds1ResponseFifoWriteEnable, ds0ResponseFifoWriteEnable}, 32'd0);
    tick();
    upstreamResponseFifoWriteEnable = 1'b0;
    check_output("t4_perr_set", 32'(protocolError), 32'd1);
    repeat (5) tick();
    check_output("t4_perr_sticky", 32'(protocolError), 32'd1);

    // Async reset part way through a port-0 chunk
    ds0_fifo.push_back(17'h00400);
    grant_q.push_back(1'b0);
    serve_chunk(1'b0, 17'h00400, 16'h5000, 11, 1'b0, 1'b0);
    upstreamResponseFifoWriteEnable = 1'b1;
    upstreamResponseFifoWriteData   = 16'h500B;
    #1;
    check_output("t5_pre_reset_we", 32'(ds0ResponseFifoWriteEnable), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check_output("t5_async_we", {30'd0, ds1ResponseFifoWriteEnable, ds0ResponseFifoWriteEnable}, 32'd0);
    check_output("t5_async_empty", 32'(upstreamRequestFifoEmpty), 32'd1);
    check_output("t5_async_perr", 32'(protocolError), 32'd0);
    check_output("t5_async_owner", 32'(owner), 32'd0);
    upstreamResponseFifoWriteEnable = 1'b0;
    ds1_fifo.push_back(17'h00999);
    repeat (2) tick();
    check_output("t5_no_grant_in_reset", 32'(ds1RequestFifoReadEnable), 32'd0);
    grant_q.push_back(1'b1);
    @(negedge scalerClock) reset = 1'b1;
    serve_chunk(1'b1, 17'h00999, 16'h6000, 32, 1'b0, 1'b0);
    check_output("t5_owner_after", 32'(owner), 32'd1);

    // Only port 1 requesting: consecutive port-1 grants
    for (int k = 0; k < 4; k++) begin
      ds1_fifo.push_back(17'h01100 + RB'(k));
      grant_q.push_back(1'b1);
    end
    for (int k = 0; k < 4; k++)
      serve_chunk(1'b1, 17'h01100 + RB'(k), 16'h7000 + 16'h0100 * PB'(k), 32, 1'b0, k < 3);

    repeat (3) tick();
    check_output("end_grant_q", grant_q.size(), 32'd0);
    check_output("end_offer_q", offer_q.size(), 32'd0);
    check_output("end_resp_q", resp_q.size(), 32'd0);
    check_output("end_perr", 32'(protocolError), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
